// File: rtl/fp_sum_sequencer.sv
// fp_sum_sequencer
//    Sums N single-precision values by driving one external adder through its
//    stb/ack operand/result interface: acc = acc + x for each element, then
//    returns the final 32-bit sum. No floating-point interpretation is done
//    here; adder results pass through untouched.
//
// Ports
//    clk, rst                      clock, asynchronous active-high reset
//    cmd_count/cmd_stb/cmd_ack     command: number of elements N
//    data_in/data_in_stb/_ack      element stream
//    add_a/add_a_stb/add_a_ack     adder operand a (accumulator)
//    add_b/add_b_stb/add_b_ack     adder operand b (element)
//    add_z/add_z_stb/add_z_ack     adder result
//    sum_out/sum_out_stb/_ack      final sum
//    busy                          high whenever not IDLE
//
// State table
//    state   | meaning
//    IDLE    | waiting for a command, cmd_ack high
//    GET_X   | taking the next element, data_in_ack high
//    SEND_A  | presenting acc to the adder as operand a
//    SEND_B  | presenting the element as operand b
//    WAIT_Z  | waiting for the adder result, add_z_ack high
//    PUT_SUM | presenting the final sum
module fp_sum_sequencer #(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COUNT_W-1:0] cmd_count,
   input  logic               cmd_stb,
   output logic               cmd_ack,
   input  logic [31:0]        data_in,
   input  logic               data_in_stb,
   output logic               data_in_ack,
   output logic [31:0]        add_a,
   output logic               add_a_stb,
   input  logic               add_a_ack,
   output logic [31:0]        add_b,
   output logic               add_b_stb,
   input  logic               add_b_ack,
   input  logic [31:0]        add_z,
   input  logic               add_z_stb,
   output logic               add_z_ack,
   output logic [31:0]        sum_out,
   output logic               sum_out_stb,
   input  logic               sum_out_ack,
   output logic               busy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GET_X   = 3'd1,
      SEND_A  = 3'd2,
      SEND_B  = 3'd3,
      WAIT_Z  = 3'd4,
      PUT_SUM = 3'd5
   } state_t;

   state_t state, state_next;

   logic [31:0]        acc;
   logic [COUNT_W-1:0] rem;

   logic cmd_xfer, data_xfer, a_xfer, b_xfer, z_xfer, sum_xfer;

   // Each ack/stb output is only ever high in its own state, so these
   // transfers cannot fire from an inactive state.
   assign cmd_xfer  = cmd_stb     & cmd_ack;
   assign data_xfer = data_in_stb & data_in_ack;
   assign a_xfer    = add_a_stb   & add_a_ack;
   assign b_xfer    = add_b_stb   & add_b_ack;
   assign z_xfer    = add_z_stb   & add_z_ack;
   assign sum_xfer  = sum_out_stb & sum_out_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (cmd_xfer) state_next = (cmd_count == '0) ? PUT_SUM : GET_X;
         end
         GET_X: begin
            if (data_xfer) state_next = SEND_A;
         end
         SEND_A: begin
            if (a_xfer) state_next = SEND_B;
         end
         SEND_B: begin
            if (b_xfer) state_next = WAIT_Z;
         end
         WAIT_Z: begin
            if (z_xfer) state_next = (rem == COUNT_W'(1)) ? PUT_SUM : GET_X;
         end
         PUT_SUM: begin
            if (sum_xfer) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs are registered copies of the next state: they rise on
   // the edge entering their state and fall on the edge of their transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_ack     <= 1'b0;
         data_in_ack <= 1'b0;
         add_a_stb   <= 1'b0;
         add_b_stb   <= 1'b0;
         add_z_ack   <= 1'b0;
         sum_out_stb <= 1'b0;
         busy        <= 1'b0;
      end else begin
         cmd_ack     <= (state_next == IDLE);
         data_in_ack <= (state_next == GET_X);
         add_a_stb   <= (state_next == SEND_A);
         add_b_stb   <= (state_next == SEND_B);
         add_z_ack   <= (state_next == WAIT_Z);
         sum_out_stb <= (state_next == PUT_SUM);
         busy        <= (state_next != IDLE);
      end
   end

   // add_b doubles as the latched element x; add_a is captured at the same
   // time so both operands are stable before their strobes rise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= 32'h0;
         rem     <= '0;
         add_a   <= 32'h0;
         add_b   <= 32'h0;
         sum_out <= 32'h0;
      end else begin
         if (cmd_xfer) begin
            acc <= 32'h0;
            rem <= cmd_count;
            if (cmd_count == '0) sum_out <= 32'h0;
         end
         if (data_xfer) begin
            add_a <= acc;
            add_b <= data_in;
         end
         if (z_xfer) begin
            acc <= add_z;
            rem <= rem - COUNT_W'(1);
            if (rem == COUNT_W'(1)) sum_out <= add_z;
         end
      end
   end

endmodule

// File: tb/tb_fp_sum_sequencer.sv
// Bench for fp_sum_sequencer: behavioural peers (command/data source, adder,
// sum sink) with random or fixed stall lengths, a scoreboard of expected
// adder operands and sums, and a negedge monitor that compares transfers.
module tb_fp_sum_sequencer;
   localparam int COUNT_W = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic [COUNT_W-1:0] cmd_count;
   logic               cmd_stb, cmd_ack;
   logic [31:0]        data_in;
   logic               data_in_stb, data_in_ack;
   logic [31:0]        add_a, add_b, add_z, sum_out;
   logic               add_a_stb, add_a_ack, add_b_stb, add_b_ack;
   logic               add_z_stb, add_z_ack, sum_out_stb, sum_out_ack;
   logic               busy;

   fp_sum_sequencer #(.COUNT_W(COUNT_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_count(cmd_count), .cmd_stb(cmd_stb), .cmd_ack(cmd_ack),
      .data_in(data_in), .data_in_stb(data_in_stb), .data_in_ack(data_in_ack),
      .add_a(add_a), .add_a_stb(add_a_stb), .add_a_ack(add_a_ack),
      .add_b(add_b), .add_b_stb(add_b_stb), .add_b_ack(add_b_ack),
      .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
      .sum_out(sum_out), .sum_out_stb(sum_out_stb), .sum_out_ack(sum_out_ack),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [31:0] exp_a[$], exp_b[$], exp_sum[$];
   int          cmd_q[$];
   logic [31:0] src_q[$];
   int          job_vals[$];
   int          sum_cnt = 0;
   int          sums_expected = 0;
   int          b_cnt = 0;
   bit          bp_mode = 1'b0;
   bit          in_op = 1'b0;
   logic [31:0] last_sum = 32'h0;
   int          a_wait = 0, b_wait = 0, z_wait = 0, s_wait = 0, src_wait = 0;

   // ---------------- float helpers (integer-valued and NaN cases only)
   function automatic real s2r(logic [31:0] f);
      logic [10:0] e;
      logic [63:0] d;
      if (f[30:23] == 8'h00) return 0.0;
      e = 11'(f[30:23]) + 11'd896;
      d = {f[31], e, f[22:0], 29'b0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2s(real r);
      logic [63:0] d;
      logic [10:0] e;
      if (r == 0.0) return 32'h0;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic bit is_nan(logic [31:0] f);
      return (f[30:23] == 8'hFF) && (f[22:0] != 23'h0);
   endfunction

   function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
      if (is_nan(a) || is_nan(b)) return 32'hFFC00000;
      return r2s(s2r(a) + s2r(b));
   endfunction

   function automatic logic [31:0] i2s(int k);
      return r2s(real'(k));
   endfunction

   function automatic int ackd();
      return bp_mode ? 5 : int'($urandom_range(0, 3));
   endfunction

   function automatic int sinkd();
      return bp_mode ? 10 : int'($urandom_range(0, 3));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- peers: command, data source, adder, sum sink
   initial begin : peers
      int  ph;
      logic [31:0] ra, rb;
      bit cx, dx, ax, bx, zx, sx;
      ph = 0; ra = 0; rb = 0;
      cmd_count = '0; cmd_stb = 0; data_in = 0; data_in_stb = 0;
      add_a_ack = 0; add_b_ack = 0; add_z = 0; add_z_stb = 0; sum_out_ack = 0;
      forever begin
         @(negedge clk);
         cx = cmd_stb && cmd_ack;
         dx = data_in_stb && data_in_ack;
         ax = add_a_stb && add_a_ack;
         bx = add_b_stb && add_b_ack;
         zx = add_z_stb && add_z_ack;
         sx = sum_out_stb && sum_out_ack;
         if (ax) ra = add_a;
         if (bx) rb = add_b;
         @(posedge clk);
         #1;
         if (rst) begin
            cmd_stb = 0; data_in_stb = 0; add_a_ack = 0; add_b_ack = 0;
            add_z_stb = 0; sum_out_ack = 0; ph = 0;
            cmd_q.delete(); src_q.delete();
            a_wait = ackd(); b_wait = ackd(); z_wait = ackd(); s_wait = sinkd();
            src_wait = 0;
         end else begin
            if (cx) cmd_stb = 0;
            else if (!cmd_stb && cmd_q.size() > 0) begin
               cmd_count = COUNT_W'(cmd_q.pop_front());
               cmd_stb = 1;
            end
            if (dx) begin
               data_in_stb = 0;
               src_wait = bp_mode ? 0 : int'($urandom_range(0, 3));
            end else if (!data_in_stb && src_q.size() > 0) begin
               if (src_wait == 0) begin
                  data_in = src_q.pop_front();
                  data_in_stb = 1;
               end else src_wait--;
            end
            if (ax) begin
               add_a_ack = 0; ph = 1; a_wait = ackd();
            end else if (ph == 0 && add_a_stb && !add_a_ack) begin
               if (a_wait == 0) add_a_ack = 1; else a_wait--;
            end
            if (bx) begin
               add_b_ack = 0; ph = 2; b_wait = ackd(); z_wait = ackd();
            end else if (ph == 1 && add_b_stb && !add_b_ack) begin
               if (b_wait == 0) add_b_ack = 1; else b_wait--;
            end
            if (zx) begin
               add_z_stb = 0; ph = 0;
            end else if (ph == 2 && !add_z_stb) begin
               if (z_wait == 0) begin
                  add_z = fadd(ra, rb);
                  add_z_stb = 1;
               end else z_wait--;
            end
            if (sx) begin
               sum_out_ack = 0; s_wait = sinkd();
            end else if (sum_out_stb && !sum_out_ack) begin
               if (s_wait == 0) sum_out_ack = 1; else s_wait--;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard
   logic        pa_stb = 0, pb_stb = 0, ps_stb = 0;
   bit          pa_x = 0, pb_x = 0, ps_x = 0;
   logic [31:0] pa = 0, pb = 0, ps = 0;

   always @(negedge clk) begin
      if (rst) begin
         pa_stb = 0; pb_stb = 0; ps_stb = 0;
         in_op = 0;
      end else begin
         check("busy", 32'(busy), 32'(in_op));
         if (cmd_stb && cmd_ack) in_op = 1;
         if (cmd_ack && data_in_stb) check("data_ack_in_idle", 32'(data_in_ack), 32'h0);
         if (pa_stb && !pa_x) begin
            check("add_a_stb_hold", 32'(add_a_stb), 32'h1);
            check("add_a_hold", add_a, pa);
         end
         if (pb_stb && !pb_x) begin
            check("add_b_stb_hold", 32'(add_b_stb), 32'h1);
            check("add_b_hold", add_b, pb);
         end
         if (ps_stb && !ps_x) begin
            check("sum_stb_hold", 32'(sum_out_stb), 32'h1);
            check("sum_hold", sum_out, ps);
         end
         pa_stb = add_a_stb; pa = add_a; pa_x = add_a_stb && add_a_ack;
         pb_stb = add_b_stb; pb = add_b; pb_x = add_b_stb && add_b_ack;
         ps_stb = sum_out_stb; ps = sum_out; ps_x = sum_out_stb && sum_out_ack;
         if (add_a_stb && add_a_ack) begin
            if (exp_a.size() == 0) begin
               checks++; failures++;
               $display("FAIL add_a_unexpected actual=%h required=none", add_a);
            end else check("add_a", add_a, exp_a.pop_front());
         end
         if (add_b_stb && add_b_ack) begin
            b_cnt++;
            if (exp_b.size() == 0) begin
               checks++; failures++;
               $display("FAIL add_b_unexpected actual=%h required=none", add_b);
            end else check("add_b", add_b, exp_b.pop_front());
         end
         if (sum_out_stb && sum_out_ack) begin
            sum_cnt++;
            last_sum = sum_out;
            in_op = 0;
            if (exp_sum.size() == 0) begin
               checks++; failures++;
               $display("FAIL sum_unexpected actual=%h required=none", sum_out);
            end else check("sum_out", sum_out, exp_sum.pop_front());
         end
      end
   end

   // ---------------- main sequence
   task automatic push_job();
      int acc = 0;
      foreach (job_vals[i]) begin
         exp_a.push_back(i2s(acc));
         exp_b.push_back(i2s(job_vals[i]));
         acc += job_vals[i];
      end
      exp_sum.push_back(i2s(acc));
      sums_expected++;
      // push command and data in one step so they can appear together
      foreach (job_vals[i]) src_q.push_back(i2s(job_vals[i]));
      cmd_q.push_back(job_vals.size());
   endtask

   task automatic wait_sum(input string name);
      int n = 0;
      while (sum_cnt < sums_expected && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_sum_count"}, 32'(sum_cnt), 32'(sums_expected));
      @(negedge clk);
      check({name, "_a_drained"}, 32'(exp_a.size()), 32'h0);
      check({name, "_b_drained"}, 32'(exp_b.size()), 32'h0);
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_cmd_ack"}, 32'(cmd_ack), 32'h0);
      check({name, "_data_in_ack"}, 32'(data_in_ack), 32'h0);
      check({name, "_add_a_stb"}, 32'(add_a_stb), 32'h0);
      check({name, "_add_b_stb"}, 32'(add_b_stb), 32'h0);
      check({name, "_add_z_ack"}, 32'(add_z_ack), 32'h0);
      check({name, "_sum_out_stb"}, 32'(sum_out_stb), 32'h0);
      check({name, "_busy"}, 32'(busy), 32'h0);
      check({name, "_add_a"}, add_a, 32'h0);
      check({name, "_add_b"}, add_b, 32'h0);
      check({name, "_sum_out"}, sum_out, 32'h0);
   endtask

   task automatic flush();
      exp_a.delete(); exp_b.delete(); exp_sum.delete();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int n, base;
      rst = 1'b1;
      #23;
      check_idle_outputs("reset");
      @(posedge clk); #3 rst = 1'b0;

      // sum of three
      job_vals = '{1, 2, 3};
      push_job();
      wait_sum("sum3");
      check("sum3_value", last_sum, 32'h40C00000);

      // N = 0
      job_vals.delete();
      push_job();
      wait_sum("n0");
      check("n0_value", last_sum, 32'h0);

      // N = 1 with NaN
      exp_a.push_back(32'h0);
      exp_b.push_back(32'h7FC00000);
      exp_sum.push_back(32'hFFC00000);
      sums_expected++;
      src_q.push_back(32'h7FC00000);
      cmd_q.push_back(1);
      wait_sum("nan");
      check("nan_value", last_sum, 32'hFFC00000);

      // backpressure
      bp_mode = 1'b1;
      a_wait = 5; b_wait = 5; z_wait = 5; s_wait = 10;
      job_vals = '{1, 2, 3};
      push_job();
      wait_sum("bp");
      check("bp_value", last_sum, 32'h40C00000);
      bp_mode = 1'b0;

      // command and data presented together while idle
      repeat (3) @(negedge clk);
      src_wait = 0;
      job_vals = '{7};
      push_job();
      wait_sum("simul");

      // random jobs
      for (int j = 0; j < 20; j++) begin
         job_vals.delete();
         n = int'($urandom_range(1, 6));
         for (int k = 0; k < n; k++) job_vals.push_back(int'($urandom_range(0, 50)));
         push_job();
         wait_sum("rand");
      end

      // reset while waiting for the second adder result of three
      job_vals = '{1, 2, 3};
      base = b_cnt;
      push_job();
      n = 0;
      while (!(b_cnt >= base + 2 && add_z_ack) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("midop_reached", 32'(b_cnt >= base + 2 && add_z_ack), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("midrst_cmd_ack", 32'(cmd_ack), 32'h0);
      check("midrst_data_in_ack", 32'(data_in_ack), 32'h0);
      check("midrst_add_a_stb", 32'(add_a_stb), 32'h0);
      check("midrst_add_b_stb", 32'(add_b_stb), 32'h0);
      check("midrst_add_z_ack", 32'(add_z_ack), 32'h0);
      check("midrst_sum_out_stb", 32'(sum_out_stb), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      flush();
      sums_expected--;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      job_vals = '{1};
      push_job();
      wait_sum("post_rst");
      check("post_rst_value", last_sum, 32'h3F800000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
